// File: rtl/usb_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_defs_pkg
// Brief    : USB PID constants and IN-scheduler state encoding.
// Revision : 1.0
// ============================================================================
package usb_defs_pkg;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        SEND    = 2'd2,
        WAIT_HS = 2'd3
    } tx_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_rr_arbiter
// Brief    : Round-robin arbiter; pointer moves past the winner on advance.
//            USB_TX_EP0_PRIORITY_EN: requester 0 always wins.
// Revision : 1.0
// ============================================================================
module usb_rr_arbiter #(
    parameter int NUM_EP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_EP-1:0] req,
    input  logic              advance,
    output logic [NUM_EP-1:0] grant,
    output logic [2:0]        grant_idx,
    output logic              grant_valid
);

    logic [2:0]        r_ptr;
    logic [NUM_EP-1:0] w_req_rr;
    int                w_cand;

`ifdef USB_TX_EP0_PRIORITY_EN
    assign w_req_rr = {req[NUM_EP-1:1], 1'b0};
`else
    assign w_req_rr = req;
`endif

    // Scan from the largest offset down so the nearest requester is kept.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = 0;
        for (int off = NUM_EP - 1; off >= 0; off--) begin
            w_cand = (int'(r_ptr) + off) % NUM_EP;
            if (w_req_rr[w_cand]) begin
                grant_idx   = 3'(w_cand);
                grant_valid = 1'b1;
            end
        end
`ifdef USB_TX_EP0_PRIORITY_EN
        if (req[0]) begin
            grant_idx   = '0;
            grant_valid = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_EP; i++) begin
            grant[i] = grant_valid && (grant_idx == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && grant_valid) begin
            r_ptr <= (grant_idx == 3'(NUM_EP - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_ep_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_tx_sched
// Brief    : IN-endpoint packet scheduler: arbitration, byte streaming,
//            handshake wait and DATA0/DATA1 toggle tracking.
//            Option macro: USB_TX_EP0_PRIORITY_EN (EP0 always wins).
// Revision : 1.0
// ============================================================================
module usb_ep_tx_sched
    import usb_defs_pkg::*;
#(
    parameter int NUM_EP     = 4,
    parameter int MAX_PKT    = 64,
    parameter int HS_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_EP-1:0]   ep_req,
    input  logic [NUM_EP*7-1:0] ep_len,
    input  logic [NUM_EP*8-1:0] ep_rd_data,
    output logic [5:0]          ep_rd_idx,
    input  logic [NUM_EP-1:0]   ep_tog_load,
    input  logic                ep_tog_val,
    output logic [NUM_EP-1:0]   ep_ack,
    output logic [NUM_EP-1:0]   ep_fail,
    output logic                tx_start,
    output logic [3:0]          tx_pid,
    output logic [7:0]          tx_byte,
    output logic                tx_byte_valid,
    input  logic                tx_byte_ready,
    output logic                tx_eop,
    input  logic                hs_valid,
    input  logic [3:0]          hs_pid,
    output logic                busy,
    output logic [2:0]          cur_ep
);

    localparam int TW = $clog2(HS_TIMEOUT + 1);

    tx_sched_state_t   r_state;
    logic [2:0]        r_ep;
    logic [6:0]        r_len;
    logic [NUM_EP-1:0] r_tog;
    logic [TW-1:0]     r_cnt;

    logic [NUM_EP-1:0] w_grant;
    logic [2:0]        w_gidx;
    logic              w_gvalid;
    logic [6:0]        w_req_len;
    logic [NUM_EP-1:0] w_ep_onehot;
    logic              w_accept;
    logic              w_last;

    usb_rr_arbiter #(.NUM_EP(NUM_EP)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (ep_req),
        .advance     (r_state == IDLE),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvalid)
    );

    always_comb begin
        w_req_len = '0;
        tx_byte   = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (w_gidx == 3'(i)) w_req_len = ep_len[7*i +: 7];
            w_ep_onehot[i] = (r_ep == 3'(i));
            if (r_state == SEND && r_len != 7'd0 && r_ep == 3'(i))
                tx_byte = ep_rd_data[8*i +: 8];
        end
        if (w_req_len > 7'(MAX_PKT)) w_req_len = 7'(MAX_PKT);
    end

    assign w_accept = tx_byte_valid && tx_byte_ready;
    assign w_last   = ({1'b0, ep_rd_idx} == r_len - 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ep          <= '0;
            r_len         <= '0;
            r_tog         <= '0;
            r_cnt         <= '0;
            ep_rd_idx     <= '0;
            ep_ack        <= '0;
            ep_fail       <= '0;
            tx_start      <= 1'b0;
            tx_pid        <= '0;
            tx_byte_valid <= 1'b0;
            tx_eop        <= 1'b0;
            busy          <= 1'b0;
            cur_ep        <= '0;
        end else begin
            ep_ack   <= '0;
            ep_fail  <= '0;
            tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gvalid) begin
                        r_ep      <= w_gidx;
                        r_len     <= w_req_len;
                        tx_pid    <= (|(w_grant & r_tog)) ? PID_DATA1 : PID_DATA0;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                        cur_ep    <= w_gidx;
                        ep_rd_idx <= '0;
                        r_state   <= START;
                    end
                end
                START: begin
                    tx_byte_valid <= (r_len != 7'd0);
                    tx_eop        <= (r_len <= 7'd1);
                    r_state       <= SEND;
                end
                SEND: begin
                    // A zero-length packet ends after its single bare-EOP cycle.
                    if (r_len == 7'd0 || (w_accept && w_last)) begin
                        tx_byte_valid <= 1'b0;
                        tx_eop        <= 1'b0;
                        ep_rd_idx     <= '0;
                        r_cnt         <= '0;
                        r_state       <= WAIT_HS;
                    end else if (w_accept) begin
                        ep_rd_idx <= ep_rd_idx + 6'd1;
                        tx_eop    <= ({1'b0, ep_rd_idx} + 7'd2 == r_len);
                    end
                end
                WAIT_HS: begin
                    if (hs_valid && hs_pid == PID_ACK) begin
                        ep_ack  <= w_ep_onehot;
                        r_tog   <= r_tog ^ w_ep_onehot;
                        busy    <= 1'b0;
                        cur_ep  <= '0;
                        r_state <= IDLE;
                    end else if (hs_valid || r_cnt == TW'(HS_TIMEOUT)) begin
                        ep_fail <= w_ep_onehot;
                        busy    <= 1'b0;
                        cur_ep  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Explicit toggle loads override the ACK flip above.
            for (int i = 0; i < NUM_EP; i++) begin
                if (ep_tog_load[i]) r_tog[i] <= ep_tog_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_ep_tx_sched
// Brief    : Directed self-checking bench for usb_ep_tx_sched.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_usb_ep_tx_sched;
    import usb_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ep_req = '0;
    logic [27:0] ep_len = '0;
    logic [31:0] ep_rd_data;
    logic [5:0]  ep_rd_idx;
    logic [3:0]  ep_tog_load = '0;
    logic        ep_tog_val = 1'b0;
    logic [3:0]  ep_ack, ep_fail;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b1;
    logic        tx_eop;
    logic        hs_valid = 1'b0;
    logic [3:0]  hs_pid = '0;
    logic        busy;
    logic [2:0]  cur_ep;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [4][64];
    logic [7:0] got_bytes [80];
    int         got_n;
    logic       got_zlp;
    logic [3:0] got_pid;
    logic [2:0] got_ep;

    usb_ep_tx_sched #(.NUM_EP(4), .MAX_PKT(64), .HS_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .ep_req(ep_req), .ep_len(ep_len),
        .ep_rd_data(ep_rd_data), .ep_rd_idx(ep_rd_idx),
        .ep_tog_load(ep_tog_load), .ep_tog_val(ep_tog_val),
        .ep_ack(ep_ack), .ep_fail(ep_fail), .tx_start(tx_start), .tx_pid(tx_pid),
        .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready),
        .tx_eop(tx_eop), .hs_valid(hs_valid), .hs_pid(hs_pid), .busy(busy), .cur_ep(cur_ep)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) ep_rd_data[8*i +: 8] = mem[i][ep_rd_idx];
    end

    task automatic do_reset();
        rst_n = 1'b0; ep_req = '0; ep_len = '0; ep_tog_load = '0;
        hs_valid = 1'b0; tx_byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Captures one packet; leaves the DUT in WAIT_HS on return.
    task automatic collect(input bit toggle_ready);
        int  n;
        int  cyc;
        bit  done;
        got_n = 0; got_zlp = 1'b0; got_pid = 'x; got_ep = 'x; done = 1'b0;
        tx_byte_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_start && n < 40);
        if (!tx_start) return;
        got_pid = tx_pid;
        got_ep  = cur_ep;
        cyc = 0;
        while (cyc < 400 && !done) begin
            if (toggle_ready) tx_byte_ready = (cyc % 2 == 0);
            @(negedge clk);
            cyc++;
            if (tx_byte_valid && tx_byte_ready) begin
                if (got_n < 80) got_bytes[got_n] = tx_byte;
                got_n++;
                if (tx_eop) done = 1'b1;
            end else if (tx_eop && !tx_byte_valid) begin
                got_zlp = 1'b1;
                done = 1'b1;
            end
        end
        tx_byte_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_hs(input logic [3:0] pid);
        hs_pid = pid; hs_valid = 1'b1;
        @(negedge clk);
        hs_valid = 1'b0; ep_tog_load = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, tx_start, tx_byte_valid, tx_eop, ep_ack, ep_fail, cur_ep, tx_pid, ep_rd_idx, tx_byte} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b start=%b valid=%b eop=%b ack=%b fail=%b cur_ep=%0d pid=%h required all 0",
                     busy, tx_start, tx_byte_valid, tx_eop, ep_ack, ep_fail, cur_ep, tx_pid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        mem[2][0] = 8'hA1; mem[2][1] = 8'hA2; mem[2][2] = 8'hA3;
        ep_len[14 +: 7] = 7'd3;
        ep_req = 4'b0100;
        collect(1'b0);
        checks++;
        if ({got_pid, got_ep} !== {PID_DATA0, 3'd2}) begin
            failures++; $display("FAIL basic_pid_ep: pid=%h ep=%0d required pid=3 ep=2", got_pid, got_ep);
        end
        checks++;
        if (got_n !== 3 || {got_bytes[0], got_bytes[1], got_bytes[2]} !== 24'hA1A2A3) begin
            failures++; $display("FAIL basic_bytes: n=%0d bytes=%h %h %h required 3 bytes A1 A2 A3",
                                 got_n, got_bytes[0], got_bytes[1], got_bytes[2]);
        end
        send_hs(PID_ACK);
        checks++;
        if ({ep_ack, ep_fail, busy} !== {4'b0100, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL basic_ack: ack=%b fail=%b busy=%b required ack=0100 fail=0000 busy=0", ep_ack, ep_fail, busy);
        end
        collect(1'b0);
        checks++;
        if (got_pid !== PID_DATA1) begin
            failures++; $display("FAIL basic_second_pid: pid=%h required b", got_pid);
        end
        ep_req = '0;
        send_hs(PID_ACK);
    endtask

    task automatic test_round_robin();
        int first;
        int second;
`ifdef USB_TX_EP0_PRIORITY_EN
        first = 0; second = 3;
`else
        first = 3; second = 0;
`endif
        do_reset();
        ep_len = {7'd1, 7'd1, 7'd1, 7'd1};
        for (int i = 0; i < 4; i++) mem[i][0] = 8'h10 + 8'(i);
        ep_req = 4'b1010;
        collect(1'b0);
        checks++;
        if (got_ep !== 3'd1 || got_bytes[0] !== 8'h11) begin
            failures++; $display("FAIL rr_first: ep=%0d byte=%h required ep=1 byte=11", got_ep, got_bytes[0]);
        end
        ep_req = 4'b1001;
        send_hs(PID_ACK);
        collect(1'b0);
        checks++;
        if (got_ep !== 3'(first) || got_pid !== PID_DATA0) begin
            failures++; $display("FAIL rr_second: ep=%0d pid=%h required ep=%0d pid=3", got_ep, got_pid, first);
        end
        ep_req[first] = 1'b0;
        send_hs(PID_ACK);
        checks++;
        if (ep_ack !== 4'(1 << first)) begin
            failures++; $display("FAIL rr_second_ack: ack=%b required %b", ep_ack, 4'(1 << first));
        end
        collect(1'b0);
        checks++;
        if (got_ep !== 3'(second)) begin
            failures++; $display("FAIL rr_third: ep=%0d required %0d", got_ep, second);
        end
        ep_req = '0;
        send_hs(PID_ACK);
    endtask

    task automatic test_zlp();
        do_reset();
        ep_len[0 +: 7] = 7'd0;
        ep_req = 4'b0001;
        collect(1'b0);
        checks++;
        if (got_zlp !== 1'b1 || got_n !== 0 || got_pid !== PID_DATA0) begin
            failures++; $display("FAIL zlp_frame: zlp=%b n=%0d pid=%h required zlp=1 n=0 pid=3", got_zlp, got_n, got_pid);
        end
        send_hs(PID_ACK);
        checks++;
        if (ep_ack !== 4'b0001) begin
            failures++; $display("FAIL zlp_ack: ack=%b required 0001", ep_ack);
        end
        collect(1'b0);
        checks++;
        if (got_pid !== PID_DATA1 || got_zlp !== 1'b1) begin
            failures++; $display("FAIL zlp_toggle: pid=%h zlp=%b required pid=b zlp=1", got_pid, got_zlp);
        end
        ep_req = '0;
        send_hs(PID_ACK);
    endtask

    task automatic test_fail();
        int k;
        do_reset();
        mem[1][0] = 8'h5A; mem[1][1] = 8'hC3;
        ep_len[7 +: 7] = 7'd2;
        ep_req = 4'b0010;
        collect(1'b0);
        send_hs(PID_NAK);
        checks++;
        if ({ep_fail, ep_ack} !== {4'b0010, 4'b0000}) begin
            failures++; $display("FAIL nak_fail: fail=%b ack=%b required fail=0010 ack=0000", ep_fail, ep_ack);
        end
        collect(1'b0);
        checks++;
        if (got_pid !== PID_DATA0 || got_n !== 2) begin
            failures++; $display("FAIL nak_retry: pid=%h n=%0d required pid=3 n=2", got_pid, got_n);
        end
        ep_req = '0;
        k = 0;
        do begin @(negedge clk); k++; end while (ep_fail === 4'b0000 && k < 400);
        checks++;
        if (k !== 256 || ep_fail !== 4'b0010 || busy !== 1'b0) begin
            failures++; $display("FAIL hs_timeout: cycles=%0d fail=%b busy=%b required cycles=256 fail=0010 busy=0", k, ep_fail, busy);
        end
    endtask

    task automatic test_long_packet();
        int bad;
        do_reset();
        for (int i = 0; i < 64; i++) mem[3][i] = 8'(i * 3 + 7);
        ep_len[21 +: 7] = 7'd64;
        ep_req = 4'b1000;
        collect(1'b1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (got_bytes[i] !== 8'(i * 3 + 7)) bad++;
        checks++;
        if (got_n !== 64 || bad !== 0) begin
            failures++; $display("FAIL long_stream: n=%0d wrong_bytes=%0d required n=64 wrong_bytes=0", got_n, bad);
        end
        send_hs(PID_ACK);
        ep_len[21 +: 7] = 7'd70;
        collect(1'b0);
        checks++;
        if (got_n !== 64 || got_pid !== PID_DATA1 || got_bytes[63] !== 8'(63 * 3 + 7)) begin
            failures++; $display("FAIL len_clamp: n=%0d pid=%h last=%h required n=64 pid=b last=c4", got_n, got_pid, got_bytes[63]);
        end
        ep_req = '0;
        send_hs(PID_ACK);
        checks++;
        if (ep_ack !== 4'b1000) begin
            failures++; $display("FAIL len_clamp_ack: ack=%b required 1000", ep_ack);
        end
    endtask

    task automatic test_tog_load_and_abort();
        int  n;
        logic [3:0] pulses;
        do_reset();
        mem[0][0] = 8'h55;
        ep_len[0 +: 7] = 7'd1;
        ep_req = 4'b0001;
        collect(1'b0);
        send_hs(PID_ACK);
        collect(1'b0);
        ep_tog_load = 4'b0001; ep_tog_val = 1'b1;
        send_hs(PID_ACK);
        collect(1'b0);
        checks++;
        if (got_pid !== PID_DATA1) begin
            failures++; $display("FAIL tog_load_wins: pid=%h required b", got_pid);
        end
        ep_req = '0;
        send_hs(PID_ACK);
        ep_len[7 +: 7] = 7'd10;
        ep_req = 4'b0010;
        tx_byte_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_start && n < 40);
        repeat (2) @(negedge clk);
        checks++;
        if (tx_byte_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL abort_setup: valid=%b busy=%b required 1 1", tx_byte_valid, busy);
        end
        rst_n = 1'b0;
        ep_req = '0;
        #1;
        checks++;
        if ({busy, tx_start, tx_byte_valid, tx_eop, ep_ack, ep_fail, cur_ep, tx_pid, ep_rd_idx, tx_byte} !== '0) begin
            failures++; $display("FAIL abort_outputs: busy=%b valid=%b eop=%b cur_ep=%0d pid=%h byte=%h required all 0",
                                 busy, tx_byte_valid, tx_eop, cur_ep, tx_pid, tx_byte);
        end
        pulses = '0;
        repeat (2) begin @(negedge clk); pulses = pulses | ep_ack | ep_fail; end
        rst_n = 1'b1;
        tx_byte_ready = 1'b1;
        repeat (4) begin @(negedge clk); pulses = pulses | ep_ack | ep_fail; end
        checks++;
        if (pulses !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_no_pulse: pulses=%b busy=%b required 0000 0", pulses, busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_zlp();
        test_fail();
        test_long_packet();
        test_tog_load_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
